// File: rtl/demux_1x4_mux_4x1_if.sv
// demux_1x4_mux_4x1_if: signal bundle for the register-file select fabric.
// master drives selects and register words; slave returns enables, buses, flags.
interface demux_1x4_mux_4x1_if #(
    parameter int WIDTH = 8
);
    logic             dwrite;
    logic [1:0]       dregsel;
    logic [1:0]       sregsel;
    logic [WIDTH-1:0] res0;
    logic [WIDTH-1:0] res1;
    logic [WIDTH-1:0] res2;
    logic [WIDTH-1:0] res3;
    logic             en0;
    logic             en1;
    logic             en2;
    logic             en3;
    logic [WIDTH-1:0] dbus;
    logic [WIDTH-1:0] sbus;
    logic [WIDTH-1:0] dbus_q;
    logic [WIDTH-1:0] sbus_q;
    logic             zero;
    logic             negative;

    modport master (
        output dwrite, dregsel, sregsel,
        output res0, res1, res2, res3,
        input  en0, en1, en2, en3,
        input  dbus, sbus, dbus_q, sbus_q,
        input  zero, negative
    );

    modport slave (
        input  dwrite, dregsel, sregsel,
        input  res0, res1, res2, res3,
        output en0, en1, en2, en3,
        output dbus, sbus, dbus_q, sbus_q,
        output zero, negative
    );
endinterface

// File: rtl/demux_1x4_mux_4x1.sv
// demux_1x4_mux_4x1: write-enable demux, two word read muxes,
// and a registered copy of both reads with d-path zero/negative flags.
module demux_1x4_mux_4x1 #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    demux_1x4_mux_4x1_if.slave bus
);
    logic [3:0]       en;
    logic [WIDTH-1:0] dbus;
    logic [WIDTH-1:0] sbus;
    logic [WIDTH-1:0] dbus_q;
    logic [WIDTH-1:0] sbus_q;
    logic             zero;
    logic             negative;

    // Decode destination select into a one-hot write enable gated by dwrite.
    always_comb begin
        en = 4'b0000;
        unique case (bus.dregsel)
            2'd0: en = {3'b000, bus.dwrite};
            2'd1: en = {2'b00, bus.dwrite, 1'b0};
            2'd2: en = {1'b0, bus.dwrite, 2'b00};
            2'd3: en = {bus.dwrite, 3'b000};
        endcase
    end

    // d-path read mux; all four codes decoded so no X escapes.
    always_comb begin
        dbus = '0;
        unique case (bus.dregsel)
            2'd0: dbus = bus.res0;
            2'd1: dbus = bus.res1;
            2'd2: dbus = bus.res2;
            2'd3: dbus = bus.res3;
        endcase
    end

    // s-path read mux, independent of the d path.
    always_comb begin
        sbus = '0;
        unique case (bus.sregsel)
            2'd0: sbus = bus.res0;
            2'd1: sbus = bus.res1;
            2'd2: sbus = bus.res2;
            2'd3: sbus = bus.res3;
        endcase
    end

    // One-cycle-delayed view of both buses; flags track the d path only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_q   <= '0;
            sbus_q   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            dbus_q   <= dbus;
            sbus_q   <= sbus;
            zero     <= (dbus == '0);
            negative <= dbus[WIDTH-1];
        end
    end

    assign bus.en0      = en[0];
    assign bus.en1      = en[1];
    assign bus.en2      = en[2];
    assign bus.en3      = en[3];
    assign bus.dbus     = dbus;
    assign bus.sbus     = sbus;
    assign bus.dbus_q   = dbus_q;
    assign bus.sbus_q   = sbus_q;
    assign bus.zero     = zero;
    assign bus.negative = negative;
endmodule

// File: tb/tb_demux_1x4_mux_4x1.sv
// tb_demux_1x4_mux_4x1: self-checking bench with a scoreboard queue
// of expected registered outputs, checked one edge after issue.
module tb_demux_1x4_mux_4x1;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] dq;
        logic [WIDTH-1:0] sq;
        logic             z;
        logic             n;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb_q[$];
    logic [WIDTH-1:0] r [4];

    demux_1x4_mux_4x1_if #(.WIDTH(WIDTH)) bus ();

    demux_1x4_mux_4x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_res();
        bus.res0 = r[0];
        bus.res1 = r[1];
        bus.res2 = r[2];
        bus.res3 = r[3];
    endtask

    function automatic logic [3:0] en_vec();
        return {bus.en3, bus.en2, bus.en1, bus.en0};
    endfunction

    task automatic push_exp();
        exp_t e;
        logic [WIDTH-1:0] d;
        d = r[bus.dregsel];
        if (!rst_n) e = '0;
        else e = '{dq: d, sq: r[bus.sregsel], z: (d == 0), n: d[WIDTH-1]};
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_dq"}, 32'(bus.dbus_q), 32'(e.dq));
        chk({tag, "_sq"}, 32'(bus.sbus_q), 32'(e.sq));
        chk({tag, "_z"}, 32'(bus.zero), 32'(e.z));
        chk({tag, "_n"}, 32'(bus.negative), 32'(e.n));
    endtask

    task automatic step(input string tag);
        push_exp();
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.dwrite  = 1'b0;
        bus.dregsel = 2'd0;
        bus.sregsel = 2'd0;
        r[0] = 8'h11; r[1] = 8'h22; r[2] = 8'h83; r[3] = 8'h00;
        drive_res();
        #2;
        chk("rst_dq", 32'(bus.dbus_q), 32'h0);
        chk("rst_sq", 32'(bus.sbus_q), 32'h0);
        chk("rst_z", 32'(bus.zero), 32'h0);
        chk("rst_n", 32'(bus.negative), 32'h0);

        bus.dwrite = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dregsel = 2'(k);
            #1;
            chk($sformatf("en_one_hot%0d", k), 32'(en_vec()), 32'(1 << k));
        end
        bus.dwrite = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.dregsel = 2'(k);
            #1;
            chk($sformatf("en_off%0d", k), 32'(en_vec()), 32'h0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        bus.dregsel = 2'd2;
        bus.sregsel = 2'd0;
        #1;
        chk("rd_dbus", 32'(bus.dbus), 32'h83);
        chk("rd_sbus", 32'(bus.sbus), 32'h11);
        step("rd_reg");
        chk("rd_neg_const", 32'(bus.negative), 32'h1);

        bus.dregsel = 2'd3;
        bus.sregsel = 2'd2;
        step("zero_reg");
        chk("zero_const", 32'(bus.zero), 32'h1);

        bus.dregsel = 2'd1;
        bus.sregsel = 2'd1;
        #1;
        chk("same_d", 32'(bus.dbus), 32'h22);
        chk("same_s", 32'(bus.sbus), 32'h22);
        r[1] = 8'h5A;
        drive_res();
        #1;
        chk("same_d_upd", 32'(bus.dbus), 32'h5A);
        chk("same_s_upd", 32'(bus.sbus), 32'h5A);
        step("same_reg");

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dq", 32'(bus.dbus_q), 32'h0);
        chk("arst_sq", 32'(bus.sbus_q), 32'h0);
        chk("arst_z", 32'(bus.zero), 32'h0);
        chk("arst_comb", 32'(bus.dbus), 32'h5A);
        for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
        bus.dregsel = 2'd2;
        bus.sregsel = 2'd3;
        step("release");

        r[1] = 8'h22;
        drive_res();
        bus.dwrite  = 1'b1;
        bus.dregsel = 2'd1;
        #1;
        chk("wr_en", 32'(en_vec()), 32'h2);
        chk("wr_dbus", 32'(bus.dbus), 32'h22);
        bus.dwrite = 1'b0;
        #1;
        chk("wr_dbus_nofb", 32'(bus.dbus), 32'h22);

        for (int i = 0; i < 8; i++) begin
            bus.dregsel = 2'($urandom_range(0, 3));
            bus.sregsel = 2'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) r[j] = 8'($urandom);
            drive_res();
            step($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_1x4_mux_4x1.md
# demux_1x4_mux_4x1

Register-file select fabric: a 1-to-4 write-enable demultiplexer and two independent 4-to-1 word read multiplexers, plus a registered copy of both read words and the destination-port status flags. It sits between the four general-purpose registers and the datapath. It decodes the destination register select into per-register write enables and routes the destination (d) and source (s) operands onto their buses. Both the routing and the decode are combinational. The registered stage provides a one-cycle-delayed view and the zero/negative flags.

## Interface
- WIDTH, 8, bit width of each register word and each read bus.
- clk  input  1  sole clock; all registered outputs update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears every registered output.
- dwrite  input  1  write request to be routed to one register.
- dregsel  input  2  destination select; drives both the demux and the d-read mux.
- sregsel  input  2  source select for the s-read mux.
- res0, res1, res2, res3  input  WIDTH each  current contents of registers 0–3.
- en0, en1, en2, en3  output  1 each  per-register write enable (combinational).
- dbus  output  WIDTH  word selected by dregsel (combinational).
- sbus  output  WIDTH  word selected by sregsel (combinational).
- dbus_q  output  WIDTH  dbus registered at the last clk rising edge.
- sbus_q  output  WIDTH  sbus registered at the last clk rising edge.
- zero  output  1  registered; 1 when dbus was all zeros at the last edge.
- negative  output  1  registered; equals dbus[WIDTH-1] at the last edge.

## Operation
- Demux: en<k> = dwrite when dregsel == k, otherwise 0, for k in 0..3.
  - At most one enable is high at any time.
  - All enables are 0 when dwrite = 0.
- d mux: dbus = res<dregsel>.
- s mux: sbus = res<sregsel>.
- dregsel == sregsel is legal; both buses then carry the same word.
- Combinational outputs depend only on current inputs. There is no latching, and rst_n and clk do not affect them.
- Registered stage, on each clk rising edge with rst_n high:
  - dbus_q <= dbus.
  - sbus_q <= sbus.
  - zero <= (dbus == 0).
  - negative <= dbus[WIDTH-1].
- Flags always reflect the d path, never the s path.
- No X propagation is permitted for any 2-bit select value; all four codes are decoded.

## Timing
- Combinational latency: 0 cycles. en*, dbus and sbus settle within the same cycle as the input change.
- A write issued through en<k> and a read of the same register in the same cycle:
  - dbus/sbus return the old contents, because res<k> changes only after the register's clock edge.
  - This fabric adds no bypass.
- Registered latency: 1 cycle. dbus_q, sbus_q, zero and negative show the values present just before the rising edge.
- Reset assertion (rst_n falls, any time):
  - dbus_q = 0, sbus_q = 0, zero = 0, negative = 0 immediately, without waiting for clk.
  - Combinational outputs are unaffected.
- While rst_n is low, the registered outputs hold 0 regardless of clk.
- After rst_n rises, the first clk rising edge captures normally. Removal is not synchronized inside the block; the integrator guarantees recovery timing.
- Reset during a write: en* still follows dwrite/dregsel. Register write gating is the registers' concern.

## Test plan
- Demux sweep: dwrite=1, dregsel 0→3 -> en one-hot 0001, 0010, 0100, 1000 (en3..en0). With dwrite=0 on all four codes -> en=0000.
- Read sweep: res0..3 = 0x11, 0x22, 0x83, 0x00.
  - dregsel=2, sregsel=0 -> dbus=0x83, sbus=0x11.
  - Next clk edge -> dbus_q=0x83, sbus_q=0x11, negative=1, zero=0.
- Zero flag: dregsel=3 (res3=0x00), one clk edge -> zero=1, negative=0, dbus_q=0x00.
- Same-select: dregsel=sregsel=1 -> dbus=sbus=0x22. Change res1 to 0x5A mid-cycle -> both buses update in the same cycle.
- Async reset: registered outputs non-zero, drop rst_n between clk edges -> all registered outputs 0 before the next edge.
  - Held low across 3 edges -> they stay 0.
  - Release -> the next edge captures the current dbus/sbus.
- Write/read same cycle: dwrite=1, dregsel=1, res1=0x22 -> en1=1 and dbus=0x22 (old value), with no combinational feedback from dwrite onto dbus.
